// File: rtl/perceptron_trainer.sv
`default_nettype none
// ============================================================================
// Module      : perceptron_trainer
// Description : Perceptron learning-rule trainer for a two-input neuron.
//               Buffers up to DEPTH labelled samples, then sweeps the
//               buffer epoch by epoch, updating w1/w2/bias with saturating
//               arithmetic, until an epoch has no errors or MAX_EPOCHS runs.
// Ports       : clk, rst_n (async, active-low)
//               load_valid/load_ready/load_x1/load_x2/load_label : sample load
//               clear, start         : buffer clear / begin training (IDLE)
//               busy, done           : training status, end-of-run pulse
//               converged, epochs    : result of the last run (held)
//               w1, w2, bias         : learned weights, weights_valid qualifier
// Revision    : 1.0 - initial release
// ============================================================================
module perceptron_trainer #(
  parameter int XW         = 4,
  parameter int WW         = 8,
  parameter int DEPTH      = 8,
  parameter int MAX_EPOCHS = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic signed [XW-1:0] load_x1,
  input  logic signed [XW-1:0] load_x2,
  input  logic                 load_label,
  input  logic                 clear,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 converged,
  output logic [3:0]           epochs,
  output logic signed [WW-1:0] w1,
  output logic signed [WW-1:0] w2,
  output logic signed [WW-1:0] bias,
  output logic                 weights_valid
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = WW + XW + 2;

  localparam logic [CW-1:0]        c_depth      = CW'(DEPTH);
  localparam logic [3:0]           c_max_epochs = 4'(MAX_EPOCHS);
  localparam logic signed [SW-1:0] c_wmax       = SW'((2 ** (WW - 1)) - 1);
  // ~(2^(n-1)-1) is exactly -2^(n-1) in two's complement.
  localparam logic signed [SW-1:0] c_wmin       = ~c_wmax;
  localparam logic signed [SW-1:0] c_one        = SW'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_EVAL      = 3'd1,
    S_UPDATE    = 3'd2,
    S_EPOCH_END = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t r_state, w_next_state;

  logic                 r_init;        // keeps load_ready low until one clock after reset
  logic [CW-1:0]        r_count;
  logic [CW-1:0]        r_idx;
  logic [CW-1:0]        r_errors;
  logic [3:0]           r_epochs;
  logic signed [WW-1:0] r_w1, r_w2, r_bias;
  logic                 r_y;
  logic                 r_converged;
  logic                 r_weights_valid;

  logic signed [XW-1:0] r_mem_x1 [DEPTH];
  logic signed [XW-1:0] r_mem_x2 [DEPTH];
  logic                 r_mem_label [DEPTH];

  logic                 w_idle, w_load_ready, w_load_fire, w_start_ok, w_last;
  logic [CW-1:0]        w_count_nxt;
  logic [3:0]           w_epochs_inc;
  logic signed [XW-1:0] w_x1, w_x2;
  logic                 w_label, w_y;
  logic signed [SW-1:0] w_x1_ext, w_x2_ext, w_w1_ext, w_w2_ext, w_bias_ext;
  logic signed [SW-1:0] w_sum, w_w1_upd, w_w2_upd, w_bias_upd;

  function automatic logic signed [WW-1:0] sat(input logic signed [SW-1:0] v);
    if (v > c_wmax)      return c_wmax[WW-1:0];
    else if (v < c_wmin) return c_wmin[WW-1:0];
    else                 return v[WW-1:0];
  endfunction

  // Load / start qualification (meaningful in IDLE only)
  assign w_idle       = (r_state == S_IDLE);
  assign w_load_ready = r_init && w_idle && (r_count < c_depth);
  assign w_load_fire  = load_valid && w_load_ready;
  assign w_count_nxt  = clear ? '0 : (r_count + CW'(w_load_fire));
  assign w_start_ok   = w_idle && start && (w_count_nxt != '0);

  // Current sample and full-width dot product
  assign w_x1    = r_mem_x1[r_idx[AW-1:0]];
  assign w_x2    = r_mem_x2[r_idx[AW-1:0]];
  assign w_label = r_mem_label[r_idx[AW-1:0]];

  assign w_x1_ext   = {{(SW-XW){w_x1[XW-1]}}, w_x1};
  assign w_x2_ext   = {{(SW-XW){w_x2[XW-1]}}, w_x2};
  assign w_w1_ext   = {{(SW-WW){r_w1[WW-1]}}, r_w1};
  assign w_w2_ext   = {{(SW-WW){r_w2[WW-1]}}, r_w2};
  assign w_bias_ext = {{(SW-WW){r_bias[WW-1]}}, r_bias};

  assign w_sum = w_w1_ext * w_x1_ext + w_w2_ext * w_x2_ext + w_bias_ext;
  // Strictly positive only: a zero sum classifies as 0, like the neuron.
  assign w_y   = !w_sum[SW-1] && (w_sum != '0);

  assign w_w1_upd   = w_label ? (w_w1_ext + w_x1_ext) : (w_w1_ext - w_x1_ext);
  assign w_w2_upd   = w_label ? (w_w2_ext + w_x2_ext) : (w_w2_ext - w_x2_ext);
  assign w_bias_upd = w_label ? (w_bias_ext + c_one)  : (w_bias_ext - c_one);

  assign w_last       = (r_idx == (r_count - CW'(1)));
  assign w_epochs_inc = r_epochs + 4'd1;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:      if (w_start_ok) w_next_state = S_EVAL;
      S_EVAL:      w_next_state = S_UPDATE;
      S_UPDATE:    w_next_state = w_last ? S_EPOCH_END : S_EVAL;
      S_EPOCH_END: begin
        if ((r_errors == '0) || (w_epochs_inc == c_max_epochs)) w_next_state = S_DONE;
        else                                                    w_next_state = S_EVAL;
      end
      S_DONE:      w_next_state = S_IDLE;
      default:     w_next_state = S_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init          <= 1'b0;
      r_count         <= '0;
      r_idx           <= '0;
      r_errors        <= '0;
      r_epochs        <= '0;
      r_w1            <= '0;
      r_w2            <= '0;
      r_bias          <= '0;
      r_y             <= 1'b0;
      r_converged     <= 1'b0;
      r_weights_valid <= 1'b0;
    end else begin
      r_init <= 1'b1;
      case (r_state)
        S_IDLE: begin
          r_count <= w_count_nxt;
          if (w_start_ok) begin
            r_w1            <= '0;
            r_w2            <= '0;
            r_bias          <= '0;
            r_epochs        <= '0;
            r_idx           <= '0;
            r_errors        <= '0;
            r_weights_valid <= 1'b0;
            r_converged     <= 1'b0;
          end
        end
        S_EVAL: r_y <= w_y;
        S_UPDATE: begin
          if (r_y != w_label) begin
            r_w1     <= sat(w_w1_upd);
            r_w2     <= sat(w_w2_upd);
            r_bias   <= sat(w_bias_upd);
            r_errors <= r_errors + CW'(1);
          end
          r_idx <= r_idx + CW'(1);
        end
        S_EPOCH_END: begin
          r_epochs <= w_epochs_inc;
          if (r_errors == '0) begin
            r_converged     <= 1'b1;
            r_weights_valid <= 1'b1;
          end else if (w_epochs_inc == c_max_epochs) begin
            r_weights_valid <= 1'b1;
          end else begin
            r_errors <= '0;
            r_idx    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Sample buffer: no reset needed, occupancy is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_load_fire && !clear) begin
      r_mem_x1[r_count[AW-1:0]]    <= load_x1;
      r_mem_x2[r_count[AW-1:0]]    <= load_x2;
      r_mem_label[r_count[AW-1:0]] <= load_label;
    end
  end

  assign load_ready    = w_load_ready;
  assign busy          = (r_state == S_EVAL) || (r_state == S_UPDATE) || (r_state == S_EPOCH_END);
  assign done          = (r_state == S_DONE);
  assign converged     = r_converged;
  assign epochs        = r_epochs;
  assign w1            = r_w1;
  assign w2            = r_w2;
  assign bias          = r_bias;
  assign weights_valid = r_weights_valid;

endmodule
`default_nettype wire

// File: tb/tb_perceptron_trainer.sv
`default_nettype none
// ============================================================================
// Module      : tb_perceptron_trainer
// Description : Directed self-checking bench for perceptron_trainer. A
//               default instance (WW=8) and a narrow instance (WW=4) for
//               weight saturation share clock and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_perceptron_trainer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Default instance
  logic              load_valid, load_label, clear, start;
  logic signed [3:0] load_x1, load_x2;
  logic              load_ready, busy, done, converged, weights_valid;
  logic [3:0]        epochs;
  logic signed [7:0] w1, w2, bias;

  // Narrow instance
  logic              s_load_valid, s_load_label, s_clear, s_start;
  logic signed [3:0] s_load_x1, s_load_x2;
  logic              s_load_ready, s_busy, s_done, s_converged, s_weights_valid;
  logic [3:0]        s_epochs;
  logic signed [3:0] s_w1, s_w2, s_bias;

  perceptron_trainer dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_x1(load_x1), .load_x2(load_x2), .load_label(load_label),
    .clear(clear), .start(start), .busy(busy), .done(done),
    .converged(converged), .epochs(epochs),
    .w1(w1), .w2(w2), .bias(bias), .weights_valid(weights_valid)
  );

  perceptron_trainer #(.XW(4), .WW(4), .DEPTH(8), .MAX_EPOCHS(15)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .load_valid(s_load_valid), .load_ready(s_load_ready),
    .load_x1(s_load_x1), .load_x2(s_load_x2), .load_label(s_load_label),
    .clear(s_clear), .start(s_start), .busy(s_busy), .done(s_done),
    .converged(s_converged), .epochs(s_epochs),
    .w1(s_w1), .w2(s_w2), .bias(s_bias), .weights_valid(s_weights_valid)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input int b, input logic l);
    load_valid = 1'b1;
    load_x1    = a[3:0];
    load_x2    = b[3:0];
    load_label = l;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic s_load(input int a, input int b, input logic l);
    s_load_valid = 1'b1;
    s_load_x1    = a[3:0];
    s_load_x2    = b[3:0];
    s_load_label = l;
    tick();
    s_load_valid = 1'b0;
  endtask

  // cyc counts cycles since the start edge; the cycle right after it is 1.
  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (!done && cyc < 400) begin
      tick();
      cyc++;
    end
  endtask

  task automatic s_wait_done(input int c0, output int cyc);
    cyc = c0;
    while (!s_done && cyc < 400) begin
      tick();
      cyc++;
    end
  endtask

  // Observe the narrow instance's weight trajectory.
  int q_w1[$];
  int prev_s_w1   = 0;
  int bias_at_e4  = 99;
  bit saw_neg8    = 1'b0;

  always @(negedge clk) begin
    if (int'(s_w1) != prev_s_w1) begin
      q_w1.push_back(int'(s_w1));
      prev_s_w1 = int'(s_w1);
      if (q_w1.size() == 8) bias_at_e4 = int'(s_bias);
    end
    if (int'(s_bias) == -8) saw_neg8 = 1'b1;
  end

  initial begin
    int cyc;
    int acc;
    int exp_w1[8];
    exp_w1 = '{7, -1, 6, -2, 5, -3, 4, -4};

    rst_n = 1'b1;
    load_valid = 0; load_label = 0; clear = 0; start = 0; load_x1 = 0; load_x2 = 0;
    s_load_valid = 0; s_load_label = 0; s_clear = 0; s_start = 0; s_load_x1 = 0; s_load_x2 = 0;

    // ---- Reset ----
    #2 rst_n = 1'b0;
    #1;
    check("rst_load_ready", load_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wv", weights_valid, 0);
    check("rst_epochs", epochs, 0);
    check("rst_w1", w1, 0);
    tick();
    tick();
    check("rst_hold_ready", load_ready, 0);
    rst_n = 1'b1;
    #1 check("rel_ready_before_edge", load_ready, 0);
    tick();
    check("rel_ready_after_edge", load_ready, 1);

    // ---- Empty start ignored ----
    start = 1'b1; tick(); start = 1'b0;
    check("empty_start_busy0", busy, 0);
    tick();
    check("empty_start_busy1", busy, 0);

    // ---- Single sample convergence ----
    load(2, 1, 1'b1);
    start = 1'b1; tick(); start = 1'b0;
    check("ss_busy", busy, 1);
    check("ss_wv_low", weights_valid, 0);
    tick(); tick();
    check("ss_e1_w1", w1, 2);
    check("ss_e1_w2", w2, 1);
    check("ss_e1_bias", bias, 1);
    wait_done(3, cyc);
    check("ss_done", done, 1);
    check("ss_latency", cyc, 7);
    check("ss_converged", converged, 1);
    check("ss_epochs", epochs, 2);
    check("ss_wv", weights_valid, 1);
    check("ss_w1", w1, 2);
    check("ss_bias", bias, 1);
    tick();
    check("ss_done_pulse", done, 0);
    check("ss_wv_held", weights_valid, 1);

    // ---- Buffer full / handshake ----
    clear = 1'b1; tick(); clear = 1'b0;
    check("clr_ready", load_ready, 1);
    acc = 0;
    for (int i = 0; i < 9; i++) begin
      load_valid = 1'b1;
      load_x1 = 4'(i);
      load_x2 = 4'(i);
      load_label = 1'b0;
      if (i == 8) check("full_9th_ready", load_ready, 0);
      acc += int'(load_ready);
      tick();
    end
    load_valid = 1'b0;
    check("full_accepted", acc, 8);
    check("full_ready_low", load_ready, 0);
    clear = 1'b1; tick(); clear = 1'b0;
    check("clr2_ready", load_ready, 1);
    start = 1'b1; tick(); start = 1'b0;
    check("clr2_start_busy", busy, 0);

    // ---- Non-separable, with disturbance while busy ----
    load(1, 1, 1'b1);
    // second sample loaded in the same cycle as start
    load_valid = 1'b1; load_x1 = 4'sd1; load_x2 = 4'sd1; load_label = 1'b0; start = 1'b1;
    tick();
    load_valid = 1'b0; start = 1'b0;
    check("ns_busy", busy, 1);
    tick(); tick(); tick();
    load_valid = 1'b1; load_x1 = 4'sd5; load_x2 = 4'sd5; load_label = 1'b1;
    clear = 1'b1; start = 1'b1;
    check("ns_ready_busy", load_ready, 0);
    tick();
    load_valid = 1'b0; clear = 1'b0; start = 1'b0;
    check("ns_busy_after_poke", busy, 1);
    wait_done(5, cyc);
    check("ns_done", done, 1);
    check("ns_latency", cyc, 76);
    check("ns_converged", converged, 0);
    check("ns_epochs", epochs, 15);
    check("ns_w1", w1, 0);
    check("ns_w2", w2, 0);
    check("ns_bias", bias, 0);
    check("ns_wv", weights_valid, 1);
    tick();
    // rerun from retained buffer: same result proves disturbance was ignored
    start = 1'b1; tick(); start = 1'b0;
    wait_done(1, cyc);
    check("ns2_latency", cyc, 76);
    check("ns2_epochs", epochs, 15);
    tick();

    // ---- Saturation on narrow instance ----
    s_load(7, 0, 1'b1);
    s_load(-8, 0, 1'b1);
    s_start = 1'b1; tick(); s_start = 1'b0;
    s_wait_done(1, cyc);
    check("sat_done", s_done, 1);
    check("sat_latency", cyc, 46);
    check("sat_converged", s_converged, 1);
    check("sat_epochs", s_epochs, 9);
    check("sat_w1", s_w1, 0);
    check("sat_w2", s_w2, 0);
    check("sat_bias", s_bias, 7);
    check("sat_bias_e4", bias_at_e4, 7);
    check("sat_never_neg8", int'(saw_neg8), 0);
    check("sat_traj_len_ok", int'(q_w1.size() >= 8), 1);
    if (q_w1.size() >= 8)
      for (int i = 0; i < 8; i++) check($sformatf("sat_w1_step%0d", i), q_w1[i], exp_w1[i]);
    tick();

    // ---- Reset mid-run ----
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    check("mr_w1_before", w1, 1);
    check("mr_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_busy", busy, 0);
    check("mr_w1", w1, 0);
    check("mr_bias", bias, 0);
    check("mr_wv", weights_valid, 0);
    check("mr_epochs", epochs, 0);
    check("mr_ready", load_ready, 0);
    tick();
    check("mr_no_done", done, 0);
    rst_n = 1'b1;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    check("mr_start_ignored", busy, 0);
    load(2, 1, 1'b1);
    start = 1'b1; tick(); start = 1'b0;
    check("mr_reload_busy", busy, 1);
    wait_done(1, cyc);
    check("mr_reload_latency", cyc, 7);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
